// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared constants, types and the segment decoder for the keypad entry block.
//   Contents:
//     KEY_STAR / KEY_SHARP   bit positions of '*' and '#' in the one-hot key vector
//     kp_state_t             press/release tracking FSM states
//     SEG_DASH / SEG_BLANK   fixed segment patterns ({g,f,e,d,c,b,a}, 1 = lit)
//     seg7_of()              BCD digit to segment pattern
package keypad_pkg;

   localparam int KEY_STAR  = 10;
   localparam int KEY_SHARP = 11;

   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      HELD  = 2'd2,
      REL   = 2'd3
   } kp_state_t;

   // Non-decimal codes never reach the display; they decode to blank.
   function automatic logic [6:0] seg7_of(input logic [3:0] bcd);
      logic [6:0] s;
      case (bcd)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Two-flop synchroniser plus press/release debounce FSM for a 12-key keypad.
//   Ports:
//     clk         system clock
//     rst         asynchronous active-high reset
//     key[11:0]   raw keypad pins
//     press_stb   high for one cycle on the edge where a press is accepted
//     press_code  key pattern of the accepted press (valid while press_stb is high)
//   press_stb is decoded from the current state so the caller can apply the
//   action on the very edge the press is accepted.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] key,
   output logic        press_stb,
   output logic [11:0] press_code
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [11:0]   key_m_q;
   logic [11:0]   key_s_q;
   kp_state_t     state_q, state_d;
   logic [11:0]   cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_m_q <= '0;
         key_s_q <= '0;
         state_q <= IDLE;
         cand_q  <= '0;
         cnt_q   <= '0;
      end else begin
         key_m_q <= key;
         key_s_q <= key_m_q;
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q holds the number of consecutive qualifying cycles already seen, so
   // the run completes when one more qualifying cycle arrives at CNT_LAST.
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      press_stb = 1'b0;
      case (state_q)
         IDLE: begin
            if (key_s_q != 12'd0) begin
               cand_d  = key_s_q;
               cnt_d   = CW'(1);
               state_d = PRESS;
            end
         end
         PRESS: begin
            if (key_s_q == cand_q) begin
               if (cnt_q == CNT_LAST) begin
                  press_stb = 1'b1;
                  cnt_d     = '0;
                  state_d   = HELD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         HELD: begin
            // No auto-repeat: stay here for as long as anything is held.
            if (key_s_q == 12'd0) begin
               cnt_d   = CW'(1);
               state_d = REL;
            end
         end
         REL: begin
            if (key_s_q != 12'd0) begin
               cnt_d   = '0;
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign press_code = cand_q;

endmodule

// File: rtl/keypad_seg_entry.sv
// keypad_seg_entry
//   Keypad digit entry buffer with commit, driving a scanned common-cathode
//   seven-segment display.
//   Ports:
//     clk, rst     system clock, asynchronous active-high reset
//     key[11:0]    raw one-hot keypad: [9:0] digits, [10] '*', [11] '#'
//     seg[6:0]     {g,f,e,d,c,b,a}, 1 = lit
//     dig_en       one-hot digit enable, bit 0 = rightmost
//     value        last committed BCD value, digit 0 in [3:0]
//     value_vld    one-cycle pulse on commit
//     digit_cnt    digits currently in the entry buffer
//     ovf          one-cycle pulse: digit pressed with the buffer full
//     key_err      one-cycle pulse: several keys accepted together
module keypad_seg_entry
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SCAN_DIV        = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [11:0]             key,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic                    value_vld,
   output logic [3:0]              digit_cnt,
   output logic                    ovf,
   output logic                    key_err
);

   localparam int BW = 4 * NUM_DIGITS;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic        press_stb;
   logic [11:0] press_code;

   keypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .press_stb (press_stb),
      .press_code(press_code)
   );

   logic [BW-1:0]         buffer_q, buffer_d;
   logic [BW-1:0]         value_q, value_d;
   logic [3:0]            digit_cnt_q, digit_cnt_d;
   logic                  value_vld_q, value_vld_d;
   logic                  ovf_q, ovf_d;
   logic                  key_err_q, key_err_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         scan_idx_q, scan_idx_d;
   logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
   logic [6:0]            seg_q, seg_d;

   logic [3:0]            digit_val;
   logic                  is_digit;
   logic                  multi_key;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buffer_q    <= '0;
         value_q     <= '0;
         digit_cnt_q <= '0;
         value_vld_q <= 1'b0;
         ovf_q       <= 1'b0;
         key_err_q   <= 1'b0;
         presc_q     <= '0;
         scan_idx_q  <= '0;
         dig_en_q    <= NUM_DIGITS'(1);
         seg_q       <= SEG_DASH;
      end else begin
         buffer_q    <= buffer_d;
         value_q     <= value_d;
         digit_cnt_q <= digit_cnt_d;
         value_vld_q <= value_vld_d;
         ovf_q       <= ovf_d;
         key_err_q   <= key_err_d;
         presc_q     <= presc_d;
         scan_idx_q  <= scan_idx_d;
         dig_en_q    <= dig_en_d;
         seg_q       <= seg_d;
      end
   end

   always_comb begin
      digit_val = 4'd0;
      is_digit  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (press_code[i]) begin
            digit_val = 4'(i);
            is_digit  = 1'b1;
         end
      end
      multi_key = ($countones(press_code) > 1);
   end

   // Entry buffer: newest digit enters at digit 0, backspace shifts right.
   always_comb begin
      buffer_d    = buffer_q;
      value_d     = value_q;
      digit_cnt_d = digit_cnt_q;
      value_vld_d = 1'b0;
      ovf_d       = 1'b0;
      key_err_d   = 1'b0;
      if (press_stb) begin
         if (multi_key) begin
            key_err_d = 1'b1;
         end else if (is_digit) begin
            if (digit_cnt_q < 4'(NUM_DIGITS)) begin
               buffer_d    = {buffer_q[BW-5:0], digit_val};
               digit_cnt_d = digit_cnt_q + 4'd1;
            end else begin
               ovf_d = 1'b1;
            end
         end else if (press_code[KEY_STAR]) begin
            if (digit_cnt_q != 4'd0) begin
               buffer_d    = {4'h0, buffer_q[BW-1:4]};
               digit_cnt_d = digit_cnt_q - 4'd1;
            end
         end else if (press_code[KEY_SHARP]) begin
            value_d     = buffer_q;
            value_vld_d = 1'b1;
            buffer_d    = '0;
            digit_cnt_d = 4'd0;
         end
      end
   end

   // Pattern for every digit position, from the buffer contents being loaded
   // this cycle so the display never lags an entry by a cycle.
   logic [7*NUM_DIGITS-1:0] digit_seg;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_seg
      assign digit_seg[7*gi +: 7] =
         (4'(gi) < digit_cnt_d)                ? seg7_of(buffer_d[4*gi +: 4]) :
         ((gi == 0) && (digit_cnt_d == 4'd0))  ? SEG_DASH :
                                                 SEG_BLANK;
   end

   // seg and dig_en are both loaded from the next scan index on the same edge.
   always_comb begin
      presc_d    = presc_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_d    = '0;
         scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
      end
      dig_en_d = NUM_DIGITS'(1) << scan_idx_d;
      seg_d    = digit_seg[7*scan_idx_d +: 7];
   end

   assign seg       = seg_q;
   assign dig_en    = dig_en_q;
   assign value     = value_q;
   assign value_vld = value_vld_q;
   assign digit_cnt = digit_cnt_q;
   assign ovf       = ovf_q;
   assign key_err   = key_err_q;

endmodule

// File: tb/tb_keypad_seg_entry.sv
// tb_keypad_seg_entry
//   Directed scenarios followed by randomized key sequences, each press checked
//   against a digit-queue model of the entry buffer and display.
module tb_keypad_seg_entry;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [11:0]   key;
   logic [6:0]    seg;
   logic [N-1:0]  dig_en;
   logic [4*N-1:0] value;
   logic          value_vld;
   logic [3:0]    digit_cnt;
   logic          ovf;
   logic          key_err;

   keypad_seg_entry #(
      .NUM_DIGITS     (N),
      .DEBOUNCE_CYCLES(D),
      .SCAN_DIV       (SD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key      (key),
      .seg      (seg),
      .dig_en   (dig_en),
      .value    (value),
      .value_vld(value_vld),
      .digit_cnt(digit_cnt),
      .ovf      (ovf),
      .key_err  (key_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: q[0] is the rightmost (newest) digit.
   int          q[$];
   logic [31:0] exp_value = 0;
   logic [6:0]  seg_tab [10];

   // Pulse monitor: counts high cycles of each pulse outside reset.
   int vld_seen = 0;
   int ovf_seen = 0;
   int err_seen = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (value_vld || ovf || key_err)
            check_eq("pulse_excl", $countones({value_vld, ovf, key_err}), 1);
         if (value_vld) vld_seen++;
         if (ovf)       ovf_seen++;
         if (key_err)   err_seen++;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_and_check(input logic [11:0] code, input int v0, input int o0, input int e0);
      int e_vld = 0;
      int e_ovf = 0;
      int e_err = 0;
      int d = 0;
      if ($countones(code) > 1) begin
         e_err = 1;
      end else if (code[11]) begin
         exp_value = 0;
         for (int i = 0; i < q.size(); i++) exp_value = exp_value + (q[i] * (16 ** i));
         q.delete();
         e_vld = 1;
      end else if (code[10]) begin
         if (q.size() > 0) void'(q.pop_front());
      end else begin
         for (int i = 0; i < 10; i++) if (code[i]) d = i;
         if (q.size() < N) q.push_front(d);
         else e_ovf = 1;
      end
      check_eq("vld_pulses", vld_seen - v0, e_vld);
      check_eq("ovf_pulses", ovf_seen - o0, e_ovf);
      check_eq("err_pulses", err_seen - e0, e_err);
      check_eq("digit_cnt", digit_cnt, q.size());
      check_eq("value", value, exp_value);
      $display("press code=%03h digit_cnt=%0d value=%04h", code, digit_cnt, value);
   endtask

   // Optional chatter (on-runs shorter than D), then a clean hold and release.
   task automatic do_press(input logic [11:0] code, input int hold, input int rel,
                           input int chat, input int chat_len);
      int v0, o0, e0, on_len, off_len;
      v0 = vld_seen; o0 = ovf_seen; e0 = err_seen;
      for (int c = 0; c < chat; c++) begin
         on_len  = (chat_len > 0) ? chat_len : $urandom_range(1, D - 1);
         off_len = (chat_len > 0) ? chat_len : $urandom_range(1, 2);
         key = code;  wait_cyc(on_len);
         key = 12'd0; wait_cyc(off_len);
      end
      key = code;  wait_cyc(hold);
      key = 12'd0; wait_cyc(rel);
      model_and_check(code, v0, o0, e0);
   endtask

   task automatic check_display();
      int prev = -1;
      int run = 0;
      bit full = 0;
      int idx;
      logic [6:0] exp_seg;
      for (int c = 0; c < 3 * N * SD; c++) begin
         idx = -1;
         for (int i = 0; i < N; i++) if (dig_en == N'(1 << i)) idx = i;
         check_eq("dig_en_onehot", $countones(dig_en), 1);
         if (idx >= 0) begin
            if (idx < q.size())                 exp_seg = seg_tab[q[idx]];
            else if (q.size() == 0 && idx == 0) exp_seg = 7'h40;
            else                                exp_seg = 7'h00;
            check_eq("seg", seg, exp_seg);
         end
         if (idx != prev) begin
            if (prev >= 0) begin
               check_eq("scan_next", idx, (prev + 1) % N);
               if (full) check_eq("scan_run", run, SD);
               full = 1;
            end
            prev = idx;
            run  = 1;
         end else begin
            run++;
         end
         wait_cyc(1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_digit_cnt"}, digit_cnt, 0);
      check_eq({tag, "_value"}, value, 0);
      check_eq({tag, "_dig_en"}, dig_en, 1);
      check_eq({tag, "_seg"}, seg, 7'h40);
      check_eq({tag, "_pulses"}, {value_vld, ovf, key_err}, 0);
   endtask

   initial begin
      int lat, v0, o0, e0;
      logic [11:0] code;
      int r, b1, b2;
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      rst = 1'b1;
      key = 12'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      wait_cyc(3);

      // 1: enter 1,2,3 then commit; first press also measures latency.
      v0 = vld_seen; o0 = ovf_seen; e0 = err_seen;
      key = 12'h002;
      lat = 0;
      while (digit_cnt == 4'd0 && lat < 20) begin
         wait_cyc(1);
         lat++;
      end
      check_eq("latency", lat, D + 2);
      wait_cyc(10 - lat);
      key = 12'd0; wait_cyc(10);
      model_and_check(12'h002, v0, o0, e0);
      do_press(12'h004, 10, 10, 0, 0);
      do_press(12'h008, 10, 10, 0, 0);
      do_press(12'h800, 10, 10, 0, 0);
      check_eq("t1_value", value, 16'h0123);

      // 2: chattering '5' gives exactly one press.
      do_press(12'h020, 10, 10, 3, 2);

      // 3: fill, overflow, backspace twice.
      do_press(12'h800, 10, 10, 0, 0);
      do_press(12'h200, 10, 10, 0, 0);
      do_press(12'h100, 10, 10, 0, 0);
      do_press(12'h080, 10, 10, 0, 0);
      do_press(12'h040, 10, 10, 0, 0);
      do_press(12'h020, 10, 10, 0, 0);
      do_press(12'h400, 10, 10, 0, 0);
      do_press(12'h400, 10, 10, 0, 0);
      check_display();

      // 4: two keys together.
      do_press(12'h808, 10, 10, 0, 0);

      // 5: display of {4,2}, then of an empty buffer.
      do_press(12'h800, 10, 10, 0, 0);
      do_press(12'h010, 10, 10, 0, 0);
      do_press(12'h004, 10, 10, 0, 0);
      check_display();
      do_press(12'h800, 10, 10, 0, 0);
      check_display();

      // 6: reset during debounce of '7'.
      do_press(12'h002, 10, 10, 0, 0);
      key = 12'h080;
      wait_cyc(4);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      key = 12'd0;
      wait_cyc(2);
      check_reset_outputs("rst_held");
      q.delete();
      exp_value = 0;
      rst = 1'b0;
      v0 = vld_seen; o0 = ovf_seen; e0 = err_seen;
      wait_cyc(20);
      check_eq("post_rst_pulses", (vld_seen - v0) + (ovf_seen - o0) + (err_seen - e0), 0);
      check_eq("post_rst_cnt", digit_cnt, 0);
      do_press(12'h080, 10, 10, 0, 0);
      check_display();

      // Randomized sequences.
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 19);
         if (r < 12) begin
            code = 12'd1 << r;
         end else if (r < 14) begin
            b1 = $urandom_range(0, 11);
            b2 = (b1 + $urandom_range(1, 11)) % 12;
            code = (12'd1 << b1) | (12'd1 << b2);
         end else begin
            code = 12'd1 << $urandom_range(0, 9);
         end
         do_press(code, $urandom_range(7, 12), $urandom_range(7, 12), $urandom_range(0, 2), 0);
         if (n % 8 == 7) check_display();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
